// File: rtl/gfp8_mac_sequencer.sv
// Operand sequencer and group accumulator for one ACX_INT_MULT_ADD dot-product slice.
// Optional macro GFP8_MAC_SEQ_SATURATE_EN: clamp each accumulation step and flag it on o_sat.
module gfp8_mac_sequencer #(
  parameter int unsigned INT_SIZE    = 8,
  parameter int unsigned NUM_MULT    = 4,
  parameter int unsigned DOUT_SIZE   = 32,
  parameter int unsigned MAC_LATENCY = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [NUM_MULT*INT_SIZE-1:0] i_din_a,
  input  logic [NUM_MULT*INT_SIZE-1:0] i_din_b,
  input  logic [7:0]                   i_beats,
  output logic [NUM_MULT*INT_SIZE-1:0] o_din_a,
  output logic [NUM_MULT*INT_SIZE-1:0] o_din_b,
  output logic                         o_load,
  output logic                         o_pipeline_ce,
  input  logic [DOUT_SIZE-1:0]         i_mac_dout,
  output logic [DOUT_SIZE-1:0]         o_result,
  output logic                         o_result_valid,
  input  logic                         i_result_ready,
  output logic                         o_sat
);

  localparam int unsigned VecW     = NUM_MULT * INT_SIZE;
  localparam int unsigned TagDepth = MAC_LATENCY + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

  state_e               state_q, state_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [8:0]           beats_total;
  logic [TagDepth-1:0]  tag_valid_q, tag_first_q, tag_last_q;
  logic                 final_q;
  logic [DOUT_SIZE-1:0] acc_q, acc_d, result_q;
  logic [VecW-1:0]      din_a_q, din_b_q;
  logic                 accept, beat_first, beat_last;
  logic                 emerge_valid, emerge_first, emerge_last;

  assign o_ready        = i_rstn && (state_q == StIdle || state_q == StRun);
  assign accept         = i_valid && o_ready;
  assign o_pipeline_ce  = i_rstn;
  assign o_din_a        = din_a_q;
  assign o_din_b        = din_b_q;
  assign o_load         = tag_first_q[0];
  assign o_result       = result_q;
  assign o_result_valid = (state_q == StHold);

  assign emerge_valid = tag_valid_q[TagDepth-1];
  assign emerge_first = tag_first_q[TagDepth-1];
  assign emerge_last  = tag_last_q[TagDepth-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_first  = 1'b0;
    beat_last   = 1'b0;
    beats_total = (i_beats == 8'd0) ? 9'd256 : {1'b0, i_beats};
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          beat_first = 1'b1;
          cnt_d      = beats_total - 9'd1;
          if (beats_total == 9'd1) begin
            beat_last = 1'b1;
            state_d   = StDrain;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            beat_last = 1'b1;
            state_d   = StDrain;
          end
        end
      end
      // final_q marks the cycle after the last partial sum was folded in.
      StDrain: if (final_q) state_d = StHold;
      StHold:  if (i_result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef GFP8_MAC_SEQ_SATURATE_EN
  logic [DOUT_SIZE:0] sum_w;
  logic               sat_acc_q, sat_acc_d, sat_q;

  always_comb begin
    sum_w     = {acc_q[DOUT_SIZE-1], acc_q} + {i_mac_dout[DOUT_SIZE-1], i_mac_dout};
    acc_d     = acc_q;
    sat_acc_d = sat_acc_q;
    if (emerge_valid) begin
      if (emerge_first) begin
        acc_d     = i_mac_dout;
        sat_acc_d = 1'b0;
      end else if (sum_w[DOUT_SIZE] != sum_w[DOUT_SIZE-1]) begin
        acc_d     = sum_w[DOUT_SIZE] ? {1'b1, {(DOUT_SIZE-1){1'b0}}}
                                     : {1'b0, {(DOUT_SIZE-1){1'b1}}};
        sat_acc_d = 1'b1;
      end else begin
        acc_d = sum_w[DOUT_SIZE-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      sat_acc_q <= sat_acc_d;
      if (state_q == StDrain && final_q) sat_q <= sat_acc_q;
    end
  end

  assign o_sat = sat_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (emerge_valid) acc_d = emerge_first ? i_mac_dout : acc_q + i_mac_dout;
  end

  assign o_sat = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tag_valid_q <= '0;
      tag_first_q <= '0;
      tag_last_q  <= '0;
      final_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      din_a_q     <= '0;
      din_b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        din_a_q <= i_din_a;
        din_b_q <= i_din_b;
      end
      tag_valid_q[0] <= accept;
      tag_first_q[0] <= beat_first;
      tag_last_q[0]  <= beat_last;
      for (int i = 1; i < TagDepth; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_first_q[i] <= tag_first_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
      end
      final_q <= emerge_valid && emerge_last;
      acc_q   <= acc_d;
      if (state_q == StDrain && final_q) result_q <= acc_q;
    end
  end

endmodule
